// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter: two-requester bitwise logic unit, round-robin ties when LOGIC_ARB_ROUND_ROBIN_EN is defined
module logic_unit_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_x,
  input  logic [WIDTH-1:0] req0_y,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_x,
  input  logic [WIDTH-1:0] req1_y,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  input  logic             rsp_ready,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state_q, state_d;
  logic [1:0] op_q, op_d;
  logic [WIDTH-1:0] x_q, x_d, y_q, y_d, rsp_data_q, rsp_data_d, res;
  logic id_q, id_d, gnt1, idle, xfer;
`ifdef LOGIC_ARB_ROUND_ROBIN_EN
  logic last_q, last_d;
  assign gnt1 = req1_valid & (~req0_valid | ~last_q);
`else
  assign gnt1 = req1_valid & ~req0_valid;
`endif
  assign idle       = (state_q == IDLE) & ~rst;
  assign req1_ready = idle & gnt1;
  assign req0_ready = idle & req0_valid & ~gnt1;
  assign xfer       = (req0_valid & req0_ready) | (req1_valid & req1_ready);
  assign res        = op_q[1] ? (op_q[0] ? ~(x_q | y_q) : x_q ^ y_q) : (op_q[0] ? x_q | y_q : x_q & y_q);
  assign rsp_valid  = state_q == RESP;
  assign rsp_id     = id_q;
  assign rsp_data   = rsp_data_q;
  assign busy       = state_q != IDLE;
  always_comb begin
    state_d    = state_q == IDLE ? (xfer ? EXEC : IDLE) : state_q == EXEC ? RESP : (rsp_ready ? IDLE : RESP);
    op_d       = xfer ? (gnt1 ? req1_op : req0_op) : op_q;
    x_d        = xfer ? (gnt1 ? req1_x : req0_x) : x_q;
    y_d        = xfer ? (gnt1 ? req1_y : req0_y) : y_q;
    id_d       = xfer ? gnt1 : id_q;
    rsp_data_d = state_q == EXEC ? res : rsp_data_q;
`ifdef LOGIC_ARB_ROUND_ROBIN_EN
    last_d     = xfer ? gnt1 : last_q;
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      op_q       <= '0;
      x_q        <= '0;
      y_q        <= '0;
      id_q       <= 1'b0;
      rsp_data_q <= '0;
`ifdef LOGIC_ARB_ROUND_ROBIN_EN
      last_q     <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      x_q        <= x_d;
      y_q        <= y_d;
      id_q       <= id_d;
      rsp_data_q <= rsp_data_d;
`ifdef LOGIC_ARB_ROUND_ROBIN_EN
      last_q     <= last_d;
`endif
    end
  end
endmodule

// File: tb/tb_logic_unit_arbiter.sv
// tb_logic_unit_arbiter: directed self-checking bench for logic_unit_arbiter
module tb_logic_unit_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic req0_valid = 1'b0, req1_valid = 1'b0, req0_ready, req1_ready;
  logic [1:0] req0_op = '0, req1_op = '0;
  logic [15:0] req0_x = '0, req0_y = '0, req1_x = '0, req1_y = '0, rsp_data;
  logic rsp_valid, rsp_id, rsp_ready = 1'b0, busy;
  int checks = 0, failures = 0;
  logic exp_g;
  always #5 clk = ~clk;
  logic_unit_arbiter #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_x(req0_x), .req0_y(req0_y),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_x(req1_x), .req1_y(req1_y),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_ready(rsp_ready), .busy(busy)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic run_op(input logic id, input logic [1:0] op, input logic [15:0] x, input logic [15:0] y, input logic [15:0] exp);
    tick();
    if (id) begin req1_valid = 1'b1; req1_op = op; req1_x = x; req1_y = y; end
    else begin req0_valid = 1'b1; req0_op = op; req0_x = x; req0_y = y; end
    #1;
    chk("op_ready", {req1_ready, req0_ready}, id ? 32'd2 : 32'd1);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    chk("op_exec_busy", {busy, rsp_valid}, 32'd2);
    tick();
    #1;
    chk("op_rsp", {rsp_valid, rsp_id, rsp_data}, {15'd0, 1'b1, id, exp});
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    #1;
    chk("op_back_idle", {busy, rsp_valid}, 32'd0);
  endtask
  initial begin
    req0_valid = 1'b1; req1_valid = 1'b1;
    tick(); tick();
    #1;
    chk("rst_readies", {req1_ready, req0_ready}, 32'd0);
    chk("rst_outputs", {busy, rsp_valid, rsp_id, rsp_data}, 32'd0);
    req0_valid = 1'b0; req1_valid = 1'b0; rst = 1'b0;
    // single requester OR, operands scrambled right after transfer
    tick();
    req0_valid = 1'b1; req0_op = 2'b01; req0_x = 16'h00F0; req0_y = 16'h0F00;
    #1;
    chk("or_ready", {req1_ready, req0_ready, busy}, 32'b010);
    tick();
    req0_op = 2'b10; req0_x = 16'hFFFF; req0_y = 16'h1234;
    #1;
    chk("or_exec", {req0_ready, busy, rsp_valid}, 32'b010);
    tick();
    req0_valid = 1'b0;
    #1;
    chk("or_rsp", {rsp_valid, rsp_id, rsp_data}, {15'd0, 1'b1, 1'b0, 16'h0FF0});
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    #1;
    chk("or_idle", {busy, rsp_valid}, 32'd0);
    run_op(1'b0, 2'b11, 16'h0000, 16'h0001, 16'hFFFE);
    run_op(1'b1, 2'b00, 16'hAAAA, 16'hFFFF, 16'hAAAA);
    // req1 XOR held by back-pressure
    tick();
    req1_valid = 1'b1; req1_op = 2'b10; req1_x = 16'hFFFF; req1_y = 16'h00FF;
    #1;
    chk("xor_ready", {req1_ready, req0_ready}, 32'd2);
    tick();
    req0_valid = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_rsp", {rsp_valid, rsp_id, rsp_data}, {15'd0, 1'b1, 1'b1, 16'hFF00});
      chk("stall_readies", {req1_ready, req0_ready}, 32'd0);
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    #1;
    chk("stall_release", {busy, rsp_valid}, 32'd0);
    // abort during EXEC after a req0 grant
    req0_valid = 1'b1; req0_op = 2'b01; req0_x = 16'h1111; req0_y = 16'h2222;
    tick();
    req0_valid = 1'b0;
    #1;
    chk("abort_exec", busy, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("abort_idle", {busy, rsp_valid, rsp_data}, 32'd0);
    tick();
    #1;
    chk("abort_no_rsp", {busy, rsp_valid}, 32'd0);
    // continuous tie with rsp_ready high
    req0_valid = 1'b1; req0_op = 2'b00; req0_x = 16'hF0F0; req0_y = 16'hFF00;
    req1_valid = 1'b1; req1_op = 2'b01; req1_x = 16'h000F; req1_y = 16'h0F00;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
`ifdef LOGIC_ARB_ROUND_ROBIN_EN
      exp_g = i[0];
`else
      exp_g = 1'b0;
`endif
      #1;
      chk("tie_grant", {req1_ready, req0_ready}, exp_g ? 32'd2 : 32'd1);
      tick();
      tick();
      #1;
      chk("tie_rsp", {rsp_valid, rsp_id, rsp_data}, {15'd0, 1'b1, exp_g, exp_g ? 16'h0F0F : 16'hF000});
      tick();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
